// File: rtl/contador_cm_n_pkg.sv
// ============================================================================
// contador_cm_n_pkg
//   Shared FSM state encoding, clog2 helper and BCD width macro.
//   Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef CONTADOR_CM_N_BCD_W_DEFINED
`define CONTADOR_CM_N_BCD_W_DEFINED
`define BCD_W(d) (4 * (d))
`endif

package contador_cm_n_pkg;

  typedef enum logic [2:0] {
    INICIAL   = 3'd0,
    ESPERA    = 3'd1,
    CONTA     = 3'd2,
    ARREDONDA = 3'd3,
    CONVERTE  = 3'd4,
    PRONTO    = 3'd5
  } estado_t;

  // Minimum of 1 so that a counter declared with this width always exists.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/contador_cm_n_if.sv
// ============================================================================
// contador_cm_n_if
//   Echo input and measurement result bundle of the sonar distance counter.
//   Revision: 1.0
// ============================================================================
`default_nettype none

interface contador_cm_n_if #(
  parameter int N      = 12,
  parameter int DIGITS = 3
);
  logic                        pulso;
  logic [N-1:0]                medida;
  logic [`BCD_W(DIGITS)-1:0]   digitos;
  logic                        pronto;
  logic                        fim;
  logic [2:0]                  db_estado;

  modport master (output pulso, input medida, digitos, pronto, fim, db_estado);
  modport slave  (input pulso, output medida, digitos, pronto, fim, db_estado);
endinterface

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// bin2bcd_seq
//   Sequential double-dabble: N add-3/shift steps, the first one on inicia.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import contador_cm_n_pkg::*;
#(
  parameter int N      = 12,
  parameter int DIGITS = 3
) (
  input  wire logic                      clock,
  input  wire logic                      reset,
  input  wire logic                      inicia,
  input  wire logic [N-1:0]              bin,
  output logic      [`BCD_W(DIGITS)-1:0] bcd,
  output logic                           pronto
);

  localparam int C_BW = `BCD_W(DIGITS);
  localparam int C_SW = C_BW + N;
  localparam int C_CW = clog2(N + 1);

  logic [C_SW-1:0] r_sr;
  logic [C_CW-1:0] r_cnt;
  logic            r_busy;
  logic [C_SW-1:0] w_first;
  logic [C_SW-1:0] w_next;

  function automatic logic [C_SW-1:0] dabble(input logic [C_SW-1:0] sr);
    logic [C_SW-1:0] t;
    t = sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (t[N+4*d +: 4] >= 4'd5)
        t[N+4*d +: 4] = t[N+4*d +: 4] + 4'd3;
    end
    return {t[C_SW-2:0], 1'b0};
  endfunction

  // Loading already performs step one, so the result is out N edges after inicia.
  assign w_first = dabble({{C_BW{1'b0}}, bin});
  assign w_next  = dabble(r_sr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      bcd    <= '0;
      pronto <= 1'b0;
    end else begin
      pronto <= 1'b0;
      if (inicia) begin
        r_sr  <= w_first;
        r_cnt <= C_CW'(N - 1);
        if (N == 1) begin
          bcd    <= w_first[C_SW-1 -: C_BW];
          pronto <= 1'b1;
          r_busy <= 1'b0;
        end else begin
          r_busy <= 1'b1;
        end
      end else if (r_busy) begin
        r_sr  <= w_next;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == C_CW'(1)) begin
          bcd    <= w_next[C_SW-1 -: C_BW];
          pronto <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/contador_cm_n.sv
// ============================================================================
// contador_cm_n
//   Sonar echo width to distance units, rounded, saturated and BCD-converted.
//   Optional: CONTADOR_CM_ARREDONDA_EN enables half-up rounding.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module contador_cm_n
  import contador_cm_n_pkg::*;
#(
  parameter int R      = 2941,
  parameter int N      = 12,
  parameter int DIGITS = 3,
  parameter int MAX    = 999
) (
  input  wire logic        clock,
  input  wire logic        reset,
  contador_cm_n_if.slave   bus
);

  localparam int C_TW = clog2(R);
  localparam int C_BW = `BCD_W(DIGITS);

  logic            r_sync1;
  logic            r_ps;
  logic            r_ps_d;
  estado_t         r_estado;
  logic [C_TW-1:0] r_tick;
  logic [N-1:0]    r_units;
  logic            r_fim;
  logic [N-1:0]    r_medida;
  logic [C_BW-1:0] r_digitos;
  logic            r_pronto;

  logic            w_rise;
  logic [N-1:0]    w_final;
  logic            w_fim_final;
  logic            w_inicia;
  logic [C_BW-1:0] w_bcd;
  logic            w_conv_pronto;

  assign w_rise   = r_ps & ~r_ps_d;
  assign w_inicia = (r_estado == ARREDONDA);

  always_comb begin
    w_final     = r_units;
    w_fim_final = r_fim;
    if (r_fim)
      w_final = N'(MAX);
`ifdef CONTADOR_CM_ARREDONDA_EN
    else if (r_tick >= C_TW'(R / 2)) begin
      if (r_units >= N'(MAX)) begin
        w_final     = N'(MAX);
        w_fim_final = 1'b1;
      end else begin
        w_final = r_units + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b0;
      r_ps      <= 1'b0;
      r_ps_d    <= 1'b0;
      r_estado  <= INICIAL;
      r_tick    <= '0;
      r_units   <= '0;
      r_fim     <= 1'b0;
      r_medida  <= '0;
      r_digitos <= '0;
      r_pronto  <= 1'b0;
    end else begin
      r_sync1 <= bus.pulso;
      r_ps    <= r_sync1;
      r_ps_d  <= r_ps;
      case (r_estado)
        INICIAL: r_estado <= ESPERA;
        ESPERA, PRONTO: begin
          // The edge-detect cycle itself is the first tick of the echo.
          if (w_rise) begin
            r_tick   <= C_TW'(1);
            r_units  <= '0;
            r_fim    <= 1'b0;
            r_pronto <= 1'b0;
            r_estado <= CONTA;
          end
        end
        CONTA: begin
          if (!r_ps)
            r_estado <= ARREDONDA;
          else if (r_fim)
            r_estado <= CONTA;
          else if (r_units == N'(MAX))
            r_fim <= 1'b1;
          else if (r_tick == C_TW'(R - 1)) begin
            r_tick  <= '0;
            r_units <= r_units + 1'b1;
          end else
            r_tick <= r_tick + 1'b1;
        end
        ARREDONDA: begin
          r_units  <= w_final;
          r_fim    <= w_fim_final;
          r_medida <= w_final;
          r_estado <= CONVERTE;
        end
        CONVERTE: begin
          if (w_conv_pronto) begin
            r_digitos <= w_bcd;
            r_pronto  <= 1'b1;
            r_estado  <= PRONTO;
          end
        end
        default: r_estado <= INICIAL;
      endcase
    end
  end

  bin2bcd_seq #(
    .N      (N),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clock  (clock),
    .reset  (reset),
    .inicia (w_inicia),
    .bin    (w_final),
    .bcd    (w_bcd),
    .pronto (w_conv_pronto)
  );

  assign bus.medida    = r_medida;
  assign bus.digitos   = r_digitos;
  assign bus.pronto    = r_pronto;
  assign bus.fim       = r_fim;
  assign bus.db_estado = r_estado;

endmodule

`default_nettype wire
